// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP address-generator sequencer.
package dsp_seq_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_TAP_S   = 3'd2,
    ST_TAP_C   = 3'd3,
    ST_ROW_ADV = 3'd4,
    ST_SER_ADV = 3'd5,
    ST_FLUSH   = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  localparam logic [3:0] SEL_INC_S   = 4'b0001;
  localparam logic [3:0] SEL_RST_S   = 4'b0010;
  localparam logic [3:0] SEL_INC_C   = 4'b0100;
  localparam logic [3:0] SEL_RST_C   = 4'b1000;
  localparam logic [3:0] SEL_ADV_ROW = SEL_INC_S | SEL_INC_C;
  localparam logic [3:0] SEL_RST_ALL = SEL_RST_S | SEL_RST_C;

  // Index width for a counter spanning 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipeline_delay.sv
// Fixed-latency delay line; contents clear synchronously on rst.
module pipeline_delay
  import dsp_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned CYCLES    = 1,
  parameter bit          SHIFT_MEM = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  if (SHIFT_MEM == 1'b0) begin : g_reg
    logic [WIDTH-1:0] r_stage [CYCLES];

    // Register chain; every stage input is muxed to zero while rst is high.
    always_ff @(posedge clk) begin
      r_stage[0] <= rst ? '0 : i_data;
      for (int unsigned k = 1; k < CYCLES; k++) begin
        r_stage[k] <= rst ? '0 : r_stage[k-1];
      end
    end

    assign o_data = r_stage[CYCLES-1];
  end else begin : g_mem
    localparam int unsigned PW = idx_width(CYCLES);
    logic [WIDTH-1:0] r_mem [CYCLES];
    logic [PW-1:0]    r_ptr;
    logic             r_full;

    // Ring buffer; the entry read this cycle was written CYCLES cycles ago.
    // Memory itself is not reset, so output is masked until refilled.
    always_ff @(posedge clk) begin
      r_mem[r_ptr] <= i_data;
      if (rst) begin
        r_ptr  <= '0;
        r_full <= 1'b0;
      end else if (r_ptr == PW'(CYCLES-1)) begin
        r_ptr  <= '0;
        r_full <= 1'b1;
      end else begin
        r_ptr  <= r_ptr + 1'b1;
      end
    end

    assign o_data = r_full ? r_mem[r_ptr] : '0;
  end

endmodule

// File: rtl/dsp_seq_ctrl.sv
// Sequencer driving addr_gen: walks series/rows/taps and marks issued ops.
module dsp_seq_ctrl
  import dsp_seq_pkg::*;
#(
  parameter int unsigned OFFSET_WIDTH = 4,
  parameter int unsigned TAPS_S       = 4,
  parameter int unsigned TAPS_C       = 2,
  parameter int unsigned NUM_ROWS     = 4,
  parameter int unsigned NUM_SERIES   = 2,
  parameter int unsigned PIPE_LAT     = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               abort,
  output logic                               busy,
  output logic                               done,
  output logic [3:0]                         addr_sel,
  output logic [OFFSET_WIDTH-1:0]            addr_ptr,
  output logic                               series_inc,
  output logic                               series_rst,
  output logic                               op_valid,
  output logic                               op_last,
  output logic                               addr_valid,
  output logic                               addr_last,
  output logic [idx_width(NUM_ROWS)-1:0]     row_idx,
  output logic [idx_width(NUM_SERIES)-1:0]   series_idx
);

  localparam int unsigned TW = OFFSET_WIDTH - 1;
  localparam int unsigned RW = idx_width(NUM_ROWS);
  localparam int unsigned SW = idx_width(NUM_SERIES);
  localparam int unsigned FW = idx_width(PIPE_LAT);
  localparam bit          HAS_C    = (TAPS_C > 0);
  localparam logic [TW-1:0] LAST_S   = TW'(TAPS_S - 1);
  localparam logic [TW-1:0] LAST_C   = TW'(HAS_C ? TAPS_C - 1 : 0);
  localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);
  localparam logic [SW-1:0] LAST_SER = SW'(NUM_SERIES - 1);
  localparam logic [FW-1:0] LAST_FL  = FW'(PIPE_LAT - 1);

  state_t        r_state, w_next, w_adv;
  logic          r_rst_q;
  logic [TW-1:0] r_tap;
  logic [RW-1:0] r_row;
  logic [SW-1:0] r_ser;
  logic [FW-1:0] r_fl;

  logic                    w_busy, w_done, w_sinc, w_srst, w_opv, w_opl;
  logic [3:0]              w_sel;
  logic [OFFSET_WIDTH-1:0] w_ptr;
  logic [1:0]              w_dly_out;

  // State register; r_rst_q masks all outputs during reset and holds INIT
  // for the first cycle after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_rst_q <= 1'b1;
    end else begin
      r_state <= w_next;
      r_rst_q <= 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    w_adv  = (r_row == LAST_ROW) ? ST_SER_ADV : ST_ROW_ADV;
    if (r_rst_q) begin
      w_next = ST_INIT;
    end else begin
      case (r_state)
        ST_INIT:    w_next = ST_IDLE;
        ST_IDLE:    if (start && !abort) w_next = ST_TAP_S;
        ST_TAP_S: begin
          if (abort)                w_next = ST_INIT;
          else if (r_tap == LAST_S) w_next = HAS_C ? ST_TAP_C : w_adv;
        end
        ST_TAP_C: begin
          if (abort)                w_next = ST_INIT;
          else if (r_tap == LAST_C) w_next = w_adv;
        end
        ST_ROW_ADV: w_next = abort ? ST_INIT : ST_TAP_S;
        ST_SER_ADV: begin
          if (abort)                 w_next = ST_INIT;
          else if (r_ser == LAST_SER) w_next = ST_FLUSH;
          else                       w_next = ST_TAP_S;
        end
        ST_FLUSH: begin
          if (abort)                w_next = ST_INIT;
          else if (r_fl == LAST_FL) w_next = ST_DONE;
        end
        ST_DONE:    w_next = abort ? ST_INIT : ST_IDLE;
        default:    w_next = ST_INIT;
      endcase
    end
  end

  // Tap/row/series/flush counters; cleared whenever heading to INIT or IDLE.
  always_ff @(posedge clk) begin
    if (rst || w_next == ST_INIT || w_next == ST_IDLE) begin
      r_tap <= '0;
      r_row <= '0;
      r_ser <= '0;
      r_fl  <= '0;
    end else begin
      case (r_state)
        ST_TAP_S:   r_tap <= (r_tap == LAST_S) ? '0 : r_tap + 1'b1;
        ST_TAP_C:   r_tap <= (r_tap == LAST_C) ? '0 : r_tap + 1'b1;
        ST_ROW_ADV: r_row <= r_row + 1'b1;
        ST_SER_ADV: begin
          r_row <= '0;
          r_ser <= (r_ser == LAST_SER) ? '0 : r_ser + 1'b1;
          r_fl  <= '0;
        end
        ST_FLUSH:   r_fl  <= (r_fl == LAST_FL) ? '0 : r_fl + 1'b1;
        ST_IDLE: begin
          r_tap <= '0;
          r_row <= '0;
          r_ser <= '0;
          r_fl  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Moore output decode from state and counters only.
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    w_sinc = 1'b0;
    w_srst = 1'b0;
    w_opv  = 1'b0;
    w_opl  = 1'b0;
    w_sel  = '0;
    w_ptr  = '0;
    if (!r_rst_q) begin
      case (r_state)
        ST_INIT: begin
          w_sel  = SEL_RST_ALL;
          w_srst = 1'b1;
          w_busy = 1'b1;
        end
        ST_TAP_S: begin
          w_busy = 1'b1;
          w_opv  = 1'b1;
          w_ptr  = {1'b0, r_tap};
          w_opl  = !HAS_C && (r_tap == LAST_S);
        end
        ST_TAP_C: begin
          w_busy = 1'b1;
          w_opv  = 1'b1;
          w_ptr  = {1'b1, r_tap};
          w_opl  = (r_tap == LAST_C);
        end
        ST_ROW_ADV: begin
          w_busy = 1'b1;
          w_sel  = SEL_ADV_ROW;
        end
        ST_SER_ADV: begin
          w_busy = 1'b1;
          w_sel  = SEL_RST_ALL;
          if (r_ser == LAST_SER) w_srst = 1'b1;
          else                   w_sinc = 1'b1;
        end
        ST_FLUSH: w_busy = 1'b1;
        ST_DONE:  w_done = 1'b1;
        default: ;
      endcase
    end
  end

  pipeline_delay #(
    .WIDTH    (2),
    .CYCLES   (PIPE_LAT),
    .SHIFT_MEM(1'b0)
  ) u_dly (
    .clk    (clk),
    .rst    (rst),
    .i_data ({w_opl, w_opv}),
    .o_data (w_dly_out)
  );

  assign busy       = w_busy;
  assign done       = w_done;
  assign addr_sel   = w_sel;
  assign addr_ptr   = w_ptr;
  assign series_inc = w_sinc;
  assign series_rst = w_srst;
  assign op_valid   = w_opv;
  assign op_last    = w_opl;
  assign addr_valid = w_dly_out[0];
  assign addr_last  = w_dly_out[1];
  assign row_idx    = r_row;
  assign series_idx = r_ser;

endmodule

// File: doc/dsp_seq_ctrl.md
Name: dsp_seq_ctrl

Overview:
Sequencer that drives the DSP address generator: the addr_sel, addr_ptr, series_inc and series_rst inputs of addr_gen. On a start pulse it walks NUM_SERIES series. Each series has NUM_ROWS rows, and each row has TAPS_S state-operand taps followed by TAPS_C common-operand taps. It marks each issued operation, and re-marks the same operation once it emerges from the generator's fixed latency. It also puts the generator's counters into a known state after reset or abort.

Parameters:
OFFSET_WIDTH, 4, width of addr_ptr; MSB selects the common counter, LSBs give the tap offset
TAPS_S, 4, state taps per row; 1..2^(OFFSET_WIDTH-1)
TAPS_C, 2, common taps per row; 0..2^(OFFSET_WIDTH-1); 0 skips common phase
NUM_ROWS, 4, rows per series; >=1
NUM_SERIES, 2, series per run; >=1
PIPE_LAT, 3, addr_gen latency from addr_ptr to addr_out; >=1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  run request; sampled only in IDLE
abort  in  1  cancel run; sampled in any state except INIT
busy  out  1  high from first tap cycle until cycle before done; also high in INIT
done  out  1  one-cycle pulse at run completion
addr_sel  out  4  [0] inc states, [1] rst states, [2] inc common, [3] rst common
addr_ptr  out  OFFSET_WIDTH  {common_sel, tap offset}
series_inc  out  1  advance series offset
series_rst  out  1  clear series offset
op_valid  out  1  addr_ptr carries a tap this cycle
op_last  out  1  last tap of the current row (with op_valid)
addr_valid  out  1  op_valid delayed PIPE_LAT cycles
addr_last  out  1  op_last delayed PIPE_LAT cycles
row_idx  out  max(1,$clog2(NUM_ROWS))  current row
series_idx  out  max(1,$clog2(NUM_SERIES))  current series

Behaviour:
- Moore outputs: every output is decoded from registered state or counters. There is no combinational path from any input to any output.
- While rst is high: all outputs 0, and state, row, series and tap counters 0.
- First cycle after rst falls: INIT state.
- States and transitions:
  - INIT (1 cycle): addr_sel=4'b1010, series_rst=1, busy=1. Next state IDLE.
  - IDLE: all outputs 0. start=1 and abort=0 → TAP_S next cycle; row, series and tap counters cleared.
  - TAP_S: op_valid=1, addr_ptr={0,tap}; tap runs 0..TAPS_S-1. At the end of the phase go to TAP_C, or skip to the advance state when TAPS_C=0.
  - TAP_C: op_valid=1, addr_ptr={1,tap}; tap runs 0..TAPS_C-1.
  - op_last=1 on the final tap of each row.
  - ROW_ADV (1 cycle, no op): entered after a row that is not the last of its series. addr_sel=4'b0101; row_idx+1. Next TAP_S.
  - SER_ADV (1 cycle, no op): entered after the last row. addr_sel=4'b1010; row_idx←0.
    - Not the last series: series_inc=1, series_idx+1, next TAP_S.
    - Last series: series_rst=1, next FLUSH.
  - FLUSH: PIPE_LAT cycles, busy=1, no ops. Next DONE.
  - DONE (1 cycle): done=1, busy=0. Next IDLE.
- The one-cycle no-op advance states are mandatory. addr_gen registers series_inc before applying it, so the bubble guarantees every tap issued after the advance sees the new offset.
- start while not in IDLE: ignored, no queuing.
- abort in TAP_S, TAP_C, ROW_ADV, SER_ADV or FLUSH → INIT next cycle.
  - No done pulse.
  - addr_valid/addr_last for operations already issued still drain from the delay line.
- abort and start together in IDLE: abort wins; stay IDLE.
- abort in DONE: done still pulses; next state INIT instead of IDLE.
- rst mid-run: immediate return to reset values. The delay line is cleared, so addr_valid=0.
- Cycle count from the start-sample edge to the done pulse, with P = TAPS_S+TAPS_C:
  NUM_SERIES·NUM_ROWS·(P+1) + PIPE_LAT + 1.
- Total op_valid cycles per run: NUM_SERIES·NUM_ROWS·P.

Decomposition:
- Package dsp_seq_pkg holds:
  - state enum (INIT, IDLE, TAP_S, TAP_C, ROW_ADV, SER_ADV, FLUSH, DONE);
  - addr_sel constants SEL_INC_S=4'b0001, SEL_RST_S=4'b0010, SEL_INC_C=4'b0100, SEL_RST_C=4'b1000;
  - SEL_ADV_ROW=SEL_INC_S|SEL_INC_C and SEL_RST_ALL=SEL_RST_S|SEL_RST_C.
- One sub-module: an instance of the existing pipeline_delay (WIDTH=2, CYCLES=PIPE_LAT, SHIFT_MEM=0) producing addr_valid and addr_last. Its contents are gated to zero on rst via a reset-aware input mux.

Test Plan:
- Release rst → INIT cycle with addr_sel=4'b1010 and series_rst=1, then IDLE with all outputs 0.
- Defaults overridden to TAPS_S=2, TAPS_C=1, ROWS=2, SERIES=2, PIPE_LAT=3. Pulse start at cycle t →
  - taps at t+1..t+3 (ptr 0,1,8), ROW_ADV at t+4;
  - SER_ADV at t+8 with series_inc=1;
  - series_rst at t+16;
  - done at t+20;
  - 12 op_valid and 12 addr_valid cycles.
- Same config with TAPS_C=0 → no ptr MSB ever set; done at t+1+2·2·3+3 = t+16.
- abort at t+5 → INIT at t+6 (addr_sel=4'b1010), IDLE at t+7; no done; addr_valid drains through t+8.
- start held high through DONE → exactly one run; a second start pulse in IDLE starts a new run.
- rst at t+6 → op_valid, addr_valid and busy all 0 next cycle; INIT follows deassertion.
